// File: rtl/mips_defs_pkg.sv
// Shared MIPS-lite definitions: opcode/funct encodings, FSM state codes and
// the select codes the control unit drives into the datapath.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  // Register index written by jal; the datapath maps REG_DST_LINK onto it.
  localparam logic [4:0] LINK_REG  = 5'd31;
  localparam int         ALU_CTR_W = 3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  localparam logic [1:0] REG_DST_RT   = 2'b00;
  localparam logic [1:0] REG_DST_RD   = 2'b01;
  localparam logic [1:0] REG_DST_LINK = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC   = 2'b10;

  localparam logic [ALU_CTR_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTR_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTR_W-1:0] ALU_OR  = 3'b010;

  // One-hot instruction class; exactly one bit is set for any op/funct.
  typedef struct packed {
    logic is_r_add;
    logic is_r_sub;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;
    logic is_ill;
  } ins_cls_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational op/funct classifier feeding the mc_ctrl FSM.
module mc_ctrl_dec
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ins_cls_t   cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls.is_r_add = 1'b1;
        else if (funct == FN_SUBU) cls.is_r_sub = 1'b1;
        else                       cls.is_ill   = 1'b1;
      end
      OP_ORI:  cls.is_ori = 1'b1;
      OP_LUI:  cls.is_lui = 1'b1;
      OP_LW:   cls.is_lw  = 1'b1;
      OP_SW:   cls.is_sw  = 1'b1;
      OP_BEQ:  cls.is_beq = 1'b1;
      OP_J:    cls.is_j   = 1'b1;
      OP_JAL:  cls.is_jal = 1'b1;
      default: cls.is_ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite main control: Moore FSM over one instruction at a
// time, outputs decoded from state and the instruction class.
module mc_ctrl
  import mips_defs::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 pc_wr,
  output logic [1:0]           npc_sel,
  output logic                 ir_wr,
  output logic                 reg_wr,
  output logic [1:0]           reg_dst,
  output logic                 alu_src,
  output logic [1:0]           ext_op,
  output logic [ALU_CTR_W-1:0] alu_ctr,
  output logic                 mem_wr,
  output logic [1:0]           mem2reg,
  output logic [3:0]           state
);

  ins_cls_t cls;
  state_t   state_q, state_d;
  logic     pc_wr_raw, ir_wr_raw, reg_wr_raw, mem_wr_raw;

  mc_ctrl_dec u_dec (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_wr_raw  = 1'b0;
    ir_wr_raw  = 1'b0;
    reg_wr_raw = 1'b0;
    mem_wr_raw = 1'b0;
    npc_sel    = NPC_PC4;
    reg_dst    = REG_DST_RT;
    alu_src    = 1'b0;
    ext_op     = EXT_ZERO;
    alu_ctr    = ALU_ADD;
    mem2reg    = M2R_ALU;

    case (state_q)
      S_FETCH: begin
        ir_wr_raw = 1'b1;
        pc_wr_raw = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (cls.is_ill)                                       state_d = S_FETCH;
        else if (cls.is_lw || cls.is_sw)                      state_d = S_MEMADR;
        else if (cls.is_r_add || cls.is_r_sub ||
                 cls.is_ori   || cls.is_lui)                  state_d = S_EXE;
        else if (cls.is_beq)                                  state_d = S_BRANCH;
        else if (cls.is_j || cls.is_jal)                      state_d = S_JUMP;
        else                                                  state_d = S_FETCH;
      end
      // Address selects stay up through the memory access cycle.
      S_MEMADR, S_MEMRD, S_MEMWR: begin
        alu_src = 1'b1;
        ext_op  = EXT_SIGN;
        alu_ctr = ALU_ADD;
        case (state_q)
          S_MEMADR: state_d = cls.is_sw ? S_MEMWR : S_MEMRD;
          S_MEMRD:  state_d = S_MEMWB;
          default: begin
            mem_wr_raw = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMWB: begin
        reg_wr_raw = 1'b1;
        reg_dst    = REG_DST_RT;
        mem2reg    = M2R_MEM;
        state_d    = S_FETCH;
      end
      S_EXE, S_ALUWB: begin
        if (cls.is_r_sub) begin
          alu_ctr = ALU_SUB;
        end else if (cls.is_ori) begin
          alu_src = 1'b1;
          ext_op  = EXT_ZERO;
          alu_ctr = ALU_OR;
        end else if (cls.is_lui) begin
          alu_src = 1'b1;
          ext_op  = EXT_LUI;
          alu_ctr = ALU_OR;
        end
        if (state_q == S_EXE) begin
          state_d = S_ALUWB;
        end else begin
          reg_wr_raw = 1'b1;
          mem2reg    = M2R_ALU;
          reg_dst    = (cls.is_r_add || cls.is_r_sub) ? REG_DST_RD : REG_DST_RT;
          state_d    = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src   = 1'b0;
        alu_ctr   = ALU_SUB;
        npc_sel   = NPC_BR;
        pc_wr_raw = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_wr_raw = 1'b1;
        npc_sel   = NPC_JMP;
        if (cls.is_jal) begin
          reg_wr_raw = 1'b1;
          reg_dst    = REG_DST_LINK;
          mem2reg    = M2R_PC;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // state_q is already FETCH during reset, but FETCH asserts enables.
  assign pc_wr  = pc_wr_raw  & ~reset;
  assign ir_wr  = ir_wr_raw  & ~reset;
  assign reg_wr = reg_wr_raw & ~reset;
  assign mem_wr = mem_wr_raw & ~reset;
  assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its
// state sequence and checks enables/selects against hand-derived values.
module tb_mc_ctrl;
  import mips_defs::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src;
  logic [1:0] npc_sel, reg_dst, ext_op, mem2reg;
  logic [2:0] alu_ctr;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .funct   (funct),
    .zero    (zero),
    .pc_wr   (pc_wr),
    .npc_sel (npc_sel),
    .ir_wr   (ir_wr),
    .reg_wr  (reg_wr),
    .reg_dst (reg_dst),
    .alu_src (alu_src),
    .ext_op  (ext_op),
    .alu_ctr (alu_ctr),
    .mem_wr  (mem_wr),
    .mem2reg (mem2reg),
    .state   (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then check state and the four write enables.
  task automatic st(input string tag, input int s, input logic pw, input logic iw,
                    input logic rw, input logic mw);
    @(negedge clk);
    chk({tag, " state"},  32'(state),  32'(s));
    chk({tag, " pc_wr"},  32'(pc_wr),  32'(pw));
    chk({tag, " ir_wr"},  32'(ir_wr),  32'(iw));
    chk({tag, " reg_wr"}, 32'(reg_wr), 32'(rw));
    chk({tag, " mem_wr"}, 32'(mem_wr), 32'(mw));
  endtask

  // Present a new instruction while sitting in FETCH.
  task automatic go(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    #1;
    chk({tag, " fetch state"}, 32'(state),   32'd0);
    chk({tag, " fetch ir_wr"}, 32'(ir_wr),   32'd1);
    chk({tag, " fetch pc_wr"}, 32'(pc_wr),   32'd1);
    chk({tag, " fetch npc"},   32'(npc_sel), 32'd0);
  endtask

  initial begin
    reset = 1'b1; op = OP_LW; funct = 6'd0; zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst state",   32'(state),   32'd0);
      chk("rst pc_wr",   32'(pc_wr),   32'd0);
      chk("rst ir_wr",   32'(ir_wr),   32'd0);
      chk("rst reg_wr",  32'(reg_wr),  32'd0);
      chk("rst mem_wr",  32'(mem_wr),  32'd0);
      chk("rst selects", {npc_sel, reg_dst, ext_op, mem2reg, alu_ctr, alu_src}, 32'd0);
    end
    reset = 1'b0;

    go("lw", OP_LW, 6'd0, 1'b0);
    st("lw d", 1, 0, 0, 0, 0);
    st("lw a", 2, 0, 0, 0, 0);
    chk("lw a alu_src", 32'(alu_src), 32'd1);
    chk("lw a ext_op",  32'(ext_op),  32'd1);
    chk("lw a alu_ctr", 32'(alu_ctr), 32'd0);
    st("lw r", 3, 0, 0, 0, 0);
    chk("lw r alu_src", 32'(alu_src), 32'd1);
    st("lw wb", 4, 0, 0, 1, 0);
    chk("lw wb mem2reg", 32'(mem2reg), 32'd1);
    chk("lw wb reg_dst", 32'(reg_dst), 32'd0);
    st("lw f", 0, 1, 1, 0, 0);

    go("sw", OP_SW, 6'd0, 1'b0);
    st("sw d", 1, 0, 0, 0, 0);
    st("sw a", 2, 0, 0, 0, 0);
    st("sw w", 5, 0, 0, 0, 1);
    chk("sw w alu_src", 32'(alu_src), 32'd1);
    chk("sw w ext_op",  32'(ext_op),  32'd1);
    st("sw f", 0, 1, 1, 0, 0);

    go("beq1", OP_BEQ, 6'd0, 1'b1);
    st("beq1 d", 1, 0, 0, 0, 0);
    st("beq1 b", 8, 1, 0, 0, 0);
    chk("beq1 npc",     32'(npc_sel), 32'd1);
    chk("beq1 alu_ctr", 32'(alu_ctr), 32'd1);
    chk("beq1 alu_src", 32'(alu_src), 32'd0);
    st("beq1 f", 0, 1, 1, 0, 0);

    go("beq0", OP_BEQ, 6'd0, 1'b0);
    st("beq0 d", 1, 0, 0, 0, 0);
    st("beq0 b", 8, 0, 0, 0, 0);
    st("beq0 f", 0, 1, 1, 0, 0);

    go("jal", OP_JAL, 6'd0, 1'b0);
    st("jal d", 1, 0, 0, 0, 0);
    st("jal j", 9, 1, 0, 1, 0);
    chk("jal npc",     32'(npc_sel), 32'd2);
    chk("jal reg_dst", 32'(reg_dst), 32'd2);
    chk("jal mem2reg", 32'(mem2reg), 32'd2);
    st("jal f", 0, 1, 1, 0, 0);

    go("j", OP_J, 6'd0, 1'b0);
    st("j d", 1, 0, 0, 0, 0);
    st("j j", 9, 1, 0, 0, 0);
    chk("j npc", 32'(npc_sel), 32'd2);
    st("j f", 0, 1, 1, 0, 0);

    go("addu", OP_RTYPE, FN_ADDU, 1'b0);
    st("addu d", 1, 0, 0, 0, 0);
    st("addu e", 6, 0, 0, 0, 0);
    chk("addu e alu_ctr", 32'(alu_ctr), 32'd0);
    chk("addu e alu_src", 32'(alu_src), 32'd0);
    st("addu wb", 7, 0, 0, 1, 0);
    chk("addu wb reg_dst", 32'(reg_dst), 32'd1);
    chk("addu wb mem2reg", 32'(mem2reg), 32'd0);
    st("addu f", 0, 1, 1, 0, 0);

    go("subu", OP_RTYPE, FN_SUBU, 1'b0);
    st("subu d", 1, 0, 0, 0, 0);
    st("subu e", 6, 0, 0, 0, 0);
    chk("subu e alu_ctr", 32'(alu_ctr), 32'd1);
    st("subu wb", 7, 0, 0, 1, 0);
    chk("subu wb reg_dst", 32'(reg_dst), 32'd1);
    chk("subu wb alu_ctr", 32'(alu_ctr), 32'd1);
    st("subu f", 0, 1, 1, 0, 0);

    go("ori", OP_ORI, 6'd0, 1'b0);
    st("ori d", 1, 0, 0, 0, 0);
    st("ori e", 6, 0, 0, 0, 0);
    chk("ori e ext_op",  32'(ext_op),  32'd0);
    chk("ori e alu_src", 32'(alu_src), 32'd1);
    chk("ori e alu_ctr", 32'(alu_ctr), 32'd2);
    st("ori wb", 7, 0, 0, 1, 0);
    chk("ori wb reg_dst", 32'(reg_dst), 32'd0);
    st("ori f", 0, 1, 1, 0, 0);

    go("lui", OP_LUI, 6'd0, 1'b0);
    st("lui d", 1, 0, 0, 0, 0);
    st("lui e", 6, 0, 0, 0, 0);
    chk("lui e ext_op",  32'(ext_op),  32'd2);
    chk("lui e alu_src", 32'(alu_src), 32'd1);
    chk("lui e alu_ctr", 32'(alu_ctr), 32'd2);
    st("lui wb", 7, 0, 0, 1, 0);
    chk("lui wb reg_dst", 32'(reg_dst), 32'd0);
    chk("lui wb ext_op",  32'(ext_op),  32'd2);
    st("lui f", 0, 1, 1, 0, 0);

    go("ill", 6'b111111, 6'd0, 1'b0);
    st("ill d", 1, 0, 0, 0, 0);
    st("ill f", 0, 1, 1, 0, 0);

    go("rfn", OP_RTYPE, 6'b000000, 1'b0);
    st("rfn d", 1, 0, 0, 0, 0);
    st("rfn f", 0, 1, 1, 0, 0);

    go("swrst", OP_SW, 6'd0, 1'b0);
    st("swrst d", 1, 0, 0, 0, 0);
    st("swrst a", 2, 0, 0, 0, 0);
    st("swrst w", 5, 0, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst mem_wr", 32'(mem_wr), 32'd0);
    chk("midrst state",  32'(state),  32'd0);
    chk("midrst ir_wr",  32'(ir_wr),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
